// File: rtl/timer_pkg.sv
// Shared types and sizing helpers for the loadable down-counter timer.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } timer_state_t;

  // Wide enough to hold PRESCALE itself, never narrower than one bit.
  function automatic int presc_width(input int prescale);
    return (prescale < 1) ? 1 : $clog2(prescale + 1);
  endfunction

  localparam int DEFAULT_PRESCALE = 1;
  localparam int DEFAULT_PRESC_W  = presc_width(DEFAULT_PRESCALE);

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk by PRESCALE while enabled; tick is the enabled terminal count.
module tick_prescaler
  import timer_pkg::*;
#(
  parameter int PRESCALE = DEFAULT_PRESCALE
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clear,
  output logic tick
);

  localparam int            W    = presc_width(PRESCALE);
  localparam logic [W-1:0]  LAST = W'(PRESCALE - 1);

  logic [W-1:0] r_cnt;

  assign tick = en && (r_cnt == LAST);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (clear || tick) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

endmodule

// File: rtl/down_counter_timer.sv
// Loadable down-counter timer with pause, expiry pulse/level and optional auto-reload.
module down_counter_timer
  import timer_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int PRESCALE    = 1,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             stop,
  output logic [WIDTH-1:0] count,
  output logic             running,
  output logic             done,
  output logic             expired
);

  timer_state_t     r_state;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_reload;
  logic             r_done;

  logic w_en;
  logic w_clear;
  logic w_tick;

  // The prescaler only advances on cycles where the FSM actually stays in RUN.
  assign w_en    = (r_state == RUN) && !load && !stop;
  assign w_clear = load ||
                   (!stop && start &&
                    (((r_state == IDLE) && (r_count != '0)) ||
                     ((r_state == DONE) && (r_reload != '0))));

  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (w_en),
    .clear (w_clear),
    .tick  (w_tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_count  <= '0;
      r_reload <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (load) begin
        r_count  <= load_value;
        r_reload <= load_value;
        r_state  <= IDLE;
      end else if (stop) begin
        if (r_state == RUN) r_state <= PAUSE;
      end else begin
        case (r_state)
          IDLE: begin
            if (start) begin
              if (r_count == '0) begin
                r_state <= DONE;
                r_done  <= 1'b1;
              end else begin
                r_state <= RUN;
              end
            end
          end
          PAUSE: begin
            if (start) r_state <= RUN;
          end
          DONE: begin
            if (start && (r_reload != '0)) begin
              r_count <= r_reload;
              r_state <= RUN;
            end
          end
          RUN: begin
            if (w_tick) begin
              if (r_count > WIDTH'(1)) begin
                r_count <= r_count - WIDTH'(1);
              end else if (r_count == WIDTH'(1)) begin
                r_count <= '0;
                r_done  <= 1'b1;
                if (!AUTO_RELOAD) r_state <= DONE;
              end else begin
                // Zero is held for one full tick before the auto-reload.
                r_count <= r_reload;
              end
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign count   = r_count;
  assign done    = r_done;
  assign running = (r_state == RUN);
  assign expired = (r_state == DONE);

endmodule

// File: tb/tb_down_counter_timer.sv
// Directed bench for down_counter_timer: three instances cover PRESCALE=1, PRESCALE=3, auto-reload.
module tb_down_counter_timer;

  logic clk;
  logic rst_n;

  logic       a_load, a_start, a_stop;
  logic [3:0] a_lv, a_count;
  logic       a_running, a_done, a_expired;

  logic       b_load, b_start, b_stop;
  logic [3:0] b_lv, b_count;
  logic       b_running, b_done, b_expired;

  logic       c_load, c_start, c_stop;
  logic [3:0] c_lv, c_count;
  logic       c_running, c_done, c_expired;

  int vectors;
  int miscompares;

  down_counter_timer #(.WIDTH(4), .PRESCALE(1), .AUTO_RELOAD(1'b0)) dut_a (
    .clk(clk), .reset(rst_n), .load(a_load), .load_value(a_lv), .start(a_start),
    .stop(a_stop), .count(a_count), .running(a_running), .done(a_done), .expired(a_expired)
  );

  down_counter_timer #(.WIDTH(4), .PRESCALE(3), .AUTO_RELOAD(1'b0)) dut_b (
    .clk(clk), .reset(rst_n), .load(b_load), .load_value(b_lv), .start(b_start),
    .stop(b_stop), .count(b_count), .running(b_running), .done(b_done), .expired(b_expired)
  );

  down_counter_timer #(.WIDTH(4), .PRESCALE(1), .AUTO_RELOAD(1'b1)) dut_c (
    .clk(clk), .reset(rst_n), .load(c_load), .load_value(c_lv), .start(c_start),
    .stop(c_stop), .count(c_count), .running(c_running), .done(c_done), .expired(c_expired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag,
                       input logic [3:0] cnt, input logic run, input logic dn, input logic ex,
                       input logic [3:0] e_cnt, input logic e_run, input logic e_dn, input logic e_ex);
    vectors += 4;
    assert (cnt === e_cnt) else begin
      miscompares++;
      $error("FAIL %s count: observed %0d expected %0d", tag, cnt, e_cnt);
    end
    assert (run === e_run) else begin
      miscompares++;
      $error("FAIL %s running: observed %b expected %b", tag, run, e_run);
    end
    assert (dn === e_dn) else begin
      miscompares++;
      $error("FAIL %s done: observed %b expected %b", tag, dn, e_dn);
    end
    assert (ex === e_ex) else begin
      miscompares++;
      $error("FAIL %s expired: observed %b expected %b", tag, ex, e_ex);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n = 1'b0;
    {a_load, a_start, a_stop} = 3'b000; a_lv = 4'd0;
    {b_load, b_start, b_stop} = 3'b000; b_lv = 4'd0;
    {c_load, c_start, c_stop} = 3'b000; c_lv = 4'd0;

    #12;
    check("a_reset", a_count, a_running, a_done, a_expired, 4'd0, 1'b0, 1'b0, 1'b0);
    check("b_reset", b_count, b_running, b_done, b_expired, 4'd0, 1'b0, 1'b0, 1'b0);
    check("c_reset", c_count, c_running, c_done, c_expired, 4'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step();

    // Basic countdown from 5.
    a_load = 1'b1; a_lv = 4'd5; step();
    check("a_load5", a_count, a_running, a_done, a_expired, 4'd5, 1'b0, 1'b0, 1'b0);
    a_load = 1'b0; a_start = 1'b1; step();
    check("a_start5", a_count, a_running, a_done, a_expired, 4'd5, 1'b1, 1'b0, 1'b0);
    a_start = 1'b0;
    for (int i = 4; i >= 1; i--) begin
      step();
      check("a_down5", a_count, a_running, a_done, a_expired, 4'(i), 1'b1, 1'b0, 1'b0);
    end
    step();
    check("a_zero5", a_count, a_running, a_done, a_expired, 4'd0, 1'b0, 1'b1, 1'b1);
    step();
    check("a_after5", a_count, a_running, a_done, a_expired, 4'd0, 1'b0, 1'b0, 1'b1);

    // Zero load: start expires at once, restart gives no new pulse.
    a_load = 1'b1; a_lv = 4'd0; step();
    check("a_load0", a_count, a_running, a_done, a_expired, 4'd0, 1'b0, 1'b0, 1'b0);
    a_load = 1'b0; a_start = 1'b1; step();
    check("a_start0", a_count, a_running, a_done, a_expired, 4'd0, 1'b0, 1'b1, 1'b1);
    step();
    check("a_restart0", a_count, a_running, a_done, a_expired, 4'd0, 1'b0, 1'b0, 1'b1);
    a_start = 1'b0;

    // Max load counts all the way down without wrapping.
    a_load = 1'b1; a_lv = 4'd15; step();
    check("a_load15", a_count, a_running, a_done, a_expired, 4'd15, 1'b0, 1'b0, 1'b0);
    a_load = 1'b0; a_start = 1'b1; step();
    check("a_start15", a_count, a_running, a_done, a_expired, 4'd15, 1'b1, 1'b0, 1'b0);
    a_start = 1'b0;
    for (int i = 14; i >= 1; i--) begin
      step();
      check("a_down15", a_count, a_running, a_done, a_expired, 4'(i), 1'b1, 1'b0, 1'b0);
    end
    step();
    check("a_zero15", a_count, a_running, a_done, a_expired, 4'd0, 1'b0, 1'b1, 1'b1);
    step();
    check("a_nowrap", a_count, a_running, a_done, a_expired, 4'd0, 1'b0, 1'b0, 1'b1);

    // Start from DONE with a nonzero reload value restarts the countdown.
    a_start = 1'b1; step();
    check("a_rearm", a_count, a_running, a_done, a_expired, 4'd15, 1'b1, 1'b0, 1'b0);
    a_start = 1'b0;

    // Load coincident with the terminal tick wins.
    a_load = 1'b1; a_lv = 4'd2; step();
    check("a_load_run", a_count, a_running, a_done, a_expired, 4'd2, 1'b0, 1'b0, 1'b0);
    a_load = 1'b0; a_start = 1'b1; step();
    a_start = 1'b0; step();
    check("a_cnt1_l", a_count, a_running, a_done, a_expired, 4'd1, 1'b1, 1'b0, 1'b0);
    a_load = 1'b1; a_lv = 4'd7; step();
    check("a_load_tick", a_count, a_running, a_done, a_expired, 4'd7, 1'b0, 1'b0, 1'b0);
    a_load = 1'b0; step();
    check("a_idle_hold", a_count, a_running, a_done, a_expired, 4'd7, 1'b0, 1'b0, 1'b0);

    // Stop coincident with the terminal tick wins.
    a_load = 1'b1; a_lv = 4'd2; step();
    a_load = 1'b0; a_start = 1'b1; step();
    a_start = 1'b0; step();
    check("a_cnt1_s", a_count, a_running, a_done, a_expired, 4'd1, 1'b1, 1'b0, 1'b0);
    a_stop = 1'b1; step();
    check("a_stop_tick", a_count, a_running, a_done, a_expired, 4'd1, 1'b0, 1'b0, 1'b0);
    a_stop = 1'b0; step();
    check("a_pause_hold", a_count, a_running, a_done, a_expired, 4'd1, 1'b0, 1'b0, 1'b0);
    a_start = 1'b1; step();
    check("a_resume", a_count, a_running, a_done, a_expired, 4'd1, 1'b1, 1'b0, 1'b0);
    a_start = 1'b0; step();
    check("a_resume_end", a_count, a_running, a_done, a_expired, 4'd0, 1'b0, 1'b1, 1'b1);

    // Stop outranks start even where stop itself does nothing.
    a_load = 1'b1; a_lv = 4'd3; step();
    a_load = 1'b0; a_start = 1'b1; a_stop = 1'b1; step();
    check("a_stop_over_start", a_count, a_running, a_done, a_expired, 4'd3, 1'b0, 1'b0, 1'b0);
    a_start = 1'b0; a_stop = 1'b0;

    // PRESCALE=3 with pause and resume mid-period.
    b_load = 1'b1; b_lv = 4'd4; step();
    check("b_load4", b_count, b_running, b_done, b_expired, 4'd4, 1'b0, 1'b0, 1'b0);
    b_load = 1'b0; b_start = 1'b1; step();
    check("b_start", b_count, b_running, b_done, b_expired, 4'd4, 1'b1, 1'b0, 1'b0);
    b_start = 1'b0;
    step(); check("b_p1", b_count, b_running, b_done, b_expired, 4'd4, 1'b1, 1'b0, 1'b0);
    step(); check("b_p2", b_count, b_running, b_done, b_expired, 4'd4, 1'b1, 1'b0, 1'b0);
    step(); check("b_tick1", b_count, b_running, b_done, b_expired, 4'd3, 1'b1, 1'b0, 1'b0);
    step(); check("b_p4", b_count, b_running, b_done, b_expired, 4'd3, 1'b1, 1'b0, 1'b0);
    b_stop = 1'b1; step();
    check("b_paused", b_count, b_running, b_done, b_expired, 4'd3, 1'b0, 1'b0, 1'b0);
    repeat (9) step();
    check("b_pause_hold", b_count, b_running, b_done, b_expired, 4'd3, 1'b0, 1'b0, 1'b0);
    b_stop = 1'b0; b_start = 1'b1; step();
    check("b_resume", b_count, b_running, b_done, b_expired, 4'd3, 1'b1, 1'b0, 1'b0);
    b_start = 1'b0; step();
    check("b_partial", b_count, b_running, b_done, b_expired, 4'd3, 1'b1, 1'b0, 1'b0);
    step();
    check("b_tick2", b_count, b_running, b_done, b_expired, 4'd2, 1'b1, 1'b0, 1'b0);
    step(); step(); step();
    check("b_tick3", b_count, b_running, b_done, b_expired, 4'd1, 1'b1, 1'b0, 1'b0);
    step(); step();
    check("b_pre_end", b_count, b_running, b_done, b_expired, 4'd1, 1'b1, 1'b0, 1'b0);
    step();
    check("b_end", b_count, b_running, b_done, b_expired, 4'd0, 1'b0, 1'b1, 1'b1);

    // Auto-reload: 1,0,2 repeating, done every third cycle, never expired.
    c_load = 1'b1; c_lv = 4'd2; step();
    check("c_load2", c_count, c_running, c_done, c_expired, 4'd2, 1'b0, 1'b0, 1'b0);
    c_load = 1'b0; c_start = 1'b1; step();
    check("c_start", c_count, c_running, c_done, c_expired, 4'd2, 1'b1, 1'b0, 1'b0);
    c_start = 1'b0;
    for (int r = 0; r < 3; r++) begin
      step(); check("c_one", c_count, c_running, c_done, c_expired, 4'd1, 1'b1, 1'b0, 1'b0);
      step(); check("c_zero", c_count, c_running, c_done, c_expired, 4'd0, 1'b1, 1'b1, 1'b0);
      step(); check("c_reload", c_count, c_running, c_done, c_expired, 4'd2, 1'b1, 1'b0, 1'b0);
    end

    // Asynchronous reset in the middle of a run.
    a_load = 1'b1; a_lv = 4'd9; step();
    a_load = 1'b0; a_start = 1'b1; step();
    a_start = 1'b0;
    step(); step(); step();
    check("a_midrun", a_count, a_running, a_done, a_expired, 4'd6, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("a_async_rst", a_count, a_running, a_done, a_expired, 4'd0, 1'b0, 1'b0, 1'b0);
    check("c_async_rst", c_count, c_running, c_done, c_expired, 4'd0, 1'b0, 1'b0, 1'b0);
    step();
    rst_n = 1'b1;
    step();
    check("a_post_rst", a_count, a_running, a_done, a_expired, 4'd0, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
